// File: rtl/mul_seq16.sv
// Sequential 16x16 shift-and-add multiplier (low 16 product bits) driving an external add/sub unit.
// Optional build macro MUL_SEQ16_EARLY_EXIT_EN stops once the remaining multiplier bits are all zero.
module mul_seq16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_run;

  // The adder only ever adds; it sees a zero addend outside RUN so add_s is harmless there.
  assign add_in1 = acc_q;
  assign add_in2 = (state_q == RUN && mplier_q[0]) ? mcand_q : '0;
  assign add_sub = 1'b0;

`ifdef MUL_SEQ16_EARLY_EXIT_EN
  assign last_run = (count_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_run = (count_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
`ifdef MUL_SEQ16_EARLY_EXIT_EN
          if (b == '0) begin
            state_d   = DONE;
            product_d = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d    = add_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // The final sum is captured directly so product changes on the edge that raises done.
        if (last_run) begin
          state_d   = DONE;
          product_d = add_s;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/mul_seq16.md
# mul_seq16

Sequential 16x16 shift-and-add multiplier that produces the low 16 bits of the product. It sits directly upstream of the 16-bit add/sub unit: each cycle it drives the adder's operands and mode, then consumes the adder's sum back as its new partial product. It gives the ALU a multiply operation without a dedicated array multiplier, using a start/busy/done handshake toward the ALU control.

## Interface
- WIDTH, 16, operand/product width; must equal the add/sub unit width (only 16 is supported)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- a  in  16  multiplicand, sampled with start
- b  in  16  multiplier, sampled with start
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, product valid
- product  out  16  low 16 bits of a*b; holds until the next done
- add_in1  out  16  to adder in1: current accumulator
- add_in2  out  16  to adder in2: shifted multiplicand, or 0
- add_sub  out  1  to adder sub: tied 0 (add only)
- add_s  in  16  from adder s; combinational return within the same cycle

## Operation
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: acc, mcand, mplier, count and product are all 0x0000/0; done=0, busy=0, ready=1.
- IDLE, start=1: mcand<=a, mplier<=b, acc<=0, count<=0, then go to RUN.
- RUN, every cycle:
  - add_in1=acc.
  - add_in2 = mplier[0] ? mcand : 0.
  - acc<=add_s.
  - mcand<=mcand<<1 (zero fill, the MSB is dropped).
  - mplier<=mplier>>1 (logical shift).
  - count<=count+1.
- RUN exit: go to DONE after the cycle in which count==15 (16 RUN cycles).
- DONE: product<=acc on entry; done=1 for exactly that one cycle; next state is IDLE.
- Arithmetic is modulo 2^16. The adder carry-out is unused. The result is correct for both signed (two's complement) and unsigned operands.
- In IDLE and DONE, add_in1=acc and add_in2=0; add_s is ignored.
- start while not in IDLE is ignored, with no queuing. start in the DONE cycle is also ignored.
- rst mid-operation aborts at once: state IDLE, product=0, no done pulse.

## Timing
- start is sampled at edge E0. RUN occupies N cycles after E0. done is high in cycle N+1 after E0. ready returns in cycle N+2.
- Without the macro, N=16 always, so done is asserted 17 cycles after start.
- product updates on the same edge that raises done, and is stable from then until the next done.
- The adder path is combinational from acc/mcand/mplier to add_s to acc within one cycle. No pipeline register sits between this block and the adder.
- Back-to-back operation: start is accepted again in the first IDLE cycle, so the minimum interval between starts is N+2 cycles.

## Configuration
- MUL_SEQ16_EARLY_EXIT_EN
  - Defined:
    - In IDLE with start=1 and b==0: go directly to DONE (N=0), and product becomes 0.
    - In RUN: go to DONE after the current cycle once (mplier>>1)==0.
    - Result: N = (index of highest set bit of b)+1.
  - Undefined: fixed N=16 regardless of operands.
- The product value is identical either way; only latency differs.

## Test plan
- a=3, b=5 -> product=0x000F. Without the macro, done exactly 17 cycles after start, one cycle wide. ready low throughout, high again in cycle 18.
- a=0xFFFF, b=0xFFFF -> product=0x0001. a=300, b=300 -> product=0x5F90 (90000 mod 65536). a=0x8000 (−32768), b=0x0002 -> 0x0000.
- Start pulses with new operands during RUN and on the done cycle -> ignored; the first product is unchanged and exactly one done pulse occurs.
- rst asserted at RUN cycle 8 of a=7, b=9 -> outputs at reset values immediately, no done. A following start with a=7, b=9 -> product=0x003F.
- With MUL_SEQ16_EARLY_EXIT_EN:
  - a=7, b=2 -> product=0x000E, done 3 cycles after start.
  - b=0 -> product=0, done 1 cycle after start.
  - b=0x8000, a=1 -> done at 17 cycles.
- Adder hookup check: add_sub constantly 0. In each RUN cycle, add_in2 equals a<<i when b[i]=1, else 0.
